// File: rtl/port_input_buffer.sv
// Per-port input FIFO feeding the 3-port switch controller; the head flit and its address are presented to the controller.
// Optional sticky overflow/underflow flag err_o is built only when PORT_BUF_ERR_EN is defined.
module port_input_buffer #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 4,
    parameter int ADDR_LSB = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              full_o,
    output logic [DATA_W-1:0] pkt_data_o,
    output logic [7:0]        pkt_addr_o,
    output logic              pkt_valid_o,
    input  logic              deq_i
`ifdef PORT_BUF_ERR_EN
    ,
    output logic              err_o
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;

    logic empty;
    logic wr_en;
    logic rd_en;

    // Status decodes only registered state, so upstream never sees a combinational path from its own inputs.
    assign empty  = (count == '0);
    assign full_o = (count == (PTR_W + 1)'(DEPTH));

    assign wr_en = valid_i && !full_o;
    assign rd_en = deq_i && !empty;

    assign pkt_valid_o = !empty;
    assign pkt_data_o  = empty ? '0 : mem[rd_ptr];
    assign pkt_addr_o  = pkt_data_o[ADDR_LSB +: 8];

    // NOTE: the storage array has no reset; the count decides what is visible, so stale words are never presented.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef PORT_BUF_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_o <= 1'b0;
        end else if ((valid_i && full_o) || (deq_i && empty)) begin
            err_o <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_port_input_buffer.sv
// Self-checking bench for port_input_buffer: directed scenarios plus random traffic against a queue-based FIFO model.
// err_o checks are compiled in only when PORT_BUF_ERR_EN is defined.
module tb_port_input_buffer;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] data_i;
    logic              valid_i;
    logic              full_o;
    logic [DATA_W-1:0] pkt_data_o;
    logic [7:0]        pkt_addr_o;
    logic              pkt_valid_o;
    logic              deq_i;
`ifdef PORT_BUF_ERR_EN
    logic              err_o;
`endif

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] q[$];
    logic              err_exp = 1'b0;

    port_input_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_LSB(0)) dut (
        .clk         (clk),
        .rst         (rst),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .full_o      (full_o),
        .pkt_data_o  (pkt_data_o),
        .pkt_addr_o  (pkt_addr_o),
        .pkt_valid_o (pkt_valid_o),
        .deq_i       (deq_i)
`ifdef PORT_BUF_ERR_EN
        ,
        .err_o       (err_o)
`endif
    );

    always #5 clk = ~clk;

    // Expected {full, valid, addr, data} straight from the queue contents.
    function automatic logic [49:0] model_vec();
        logic [31:0] head;
        logic        f;
        logic        v;
        head = (q.size() != 0) ? q[0] : 32'h0;
        f    = (q.size() == DEPTH);
        v    = (q.size() != 0);
        return {f, v, head[7:0], 8'h00, head};
    endfunction

    function automatic logic [49:0] obs_vec();
        return {full_o, pkt_valid_o, pkt_addr_o, 8'h00, pkt_data_o};
    endfunction

    // One clock of stimulus; the model applies the FIFO rules using pre-edge occupancy.
    task automatic step(input logic v, input logic [31:0] d, input logic dq);
        bit was_full;
        bit was_empty;
        valid_i = v;
        data_i  = d;
        deq_i   = dq;
        @(posedge clk);
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        if ((v && was_full) || (dq && was_empty)) err_exp = 1'b1;
        if (dq && !was_empty) void'(q.pop_front());
        if (v && !was_full) q.push_back(d);
        #1;
        valid_i = 1'b0;
        deq_i   = 1'b0;
        data_i  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        q.delete();
        err_exp = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_i = 1'b0; deq_i = 1'b0; data_i = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        step(1'b0, 32'h0, 1'b0);
        checks++;
        if (obs_vec() !== 50'h0) begin
            errors++;
            $display("FAIL reset_idle: got %h expected %h", obs_vec(), 50'h0);
        end
    endtask

    task automatic test_fill_drain();
        logic [31:0] pattern [4];
        pattern = '{32'h000000A1, 32'h000000B2, 32'h000000C3, 32'h000000D4};
        do_reset();
        step(1'b1, pattern[0], 1'b0);
        checks++;
        if ({pkt_valid_o, pkt_addr_o} !== {1'b1, 8'hA1}) begin
            errors++;
            $display("FAIL first_write: got valid=%b addr=%h expected valid=1 addr=a1", pkt_valid_o, pkt_addr_o);
        end
        for (int i = 1; i < 4; i++) step(1'b1, pattern[i], 1'b0);
        checks++;
        if (full_o !== 1'b1) begin
            errors++;
            $display("FAIL full_after_four: got %b expected 1", full_o);
        end
        step(1'b1, 32'h000000E5, 1'b0);
        checks++;
        if (obs_vec() !== model_vec()) begin
            errors++;
            $display("FAIL fifth_write_dropped: got %h expected %h", obs_vec(), model_vec());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (pkt_data_o !== pattern[i]) begin
                errors++;
                $display("FAIL drain_order[%0d]: got %h expected %h", i, pkt_data_o, pattern[i]);
            end
            step(1'b0, 32'h0, 1'b1);
        end
        checks++;
        if ({pkt_valid_o, pkt_data_o} !== 33'h0) begin
            errors++;
            $display("FAIL drained_empty: got valid=%b data=%h expected 0/0", pkt_valid_o, pkt_data_o);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(1'b1, $urandom, 1'b0);
        step(1'b1, $urandom, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, $urandom, 1'b1);
            checks++;
            if (q.size() != 2 || obs_vec() !== model_vec()) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got %h expected %h (model depth %0d)", i, obs_vec(), model_vec(), q.size());
            end
        end
    endtask

    task automatic test_full_pop();
        logic [31:0] late;
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, $urandom, 1'b0);
        step(1'b1, 32'hDEAD0001, 1'b1);
        checks++;
        if (full_o !== 1'b0 || obs_vec() !== model_vec()) begin
            errors++;
            $display("FAIL full_pop: got %h expected %h", obs_vec(), model_vec());
        end
        late = 32'h12345678;
        step(1'b1, late, 1'b0);
        checks++;
        if (full_o !== 1'b1) begin
            errors++;
            $display("FAIL full_refill: got %b expected 1", full_o);
        end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (obs_vec() !== model_vec()) begin
                errors++;
                $display("FAIL full_pop_drain[%0d]: got %h expected %h", i, obs_vec(), model_vec());
            end
            if (i == DEPTH - 1) begin
                checks++;
                if (pkt_data_o !== late) begin
                    errors++;
                    $display("FAIL late_write_last: got %h expected %h", pkt_data_o, late);
                end
            end
            step(1'b0, 32'h0, 1'b1);
        end
    endtask

    task automatic test_empty_enq();
        do_reset();
        step(1'b1, 32'h00000055, 1'b1);
        checks++;
        if ({pkt_valid_o, pkt_addr_o, q.size() == 1} !== {1'b1, 8'h55, 1'b1}) begin
            errors++;
            $display("FAIL empty_enq: got valid=%b addr=%h expected valid=1 addr=55", pkt_valid_o, pkt_addr_o);
        end
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        checks++;
        if (obs_vec() !== 50'h0) begin
            errors++;
            $display("FAIL deq_on_empty: got %h expected %h", obs_vec(), 50'h0);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, $urandom | 32'h1, 1'b0);
        rst = 1'b1;
        #2;
        checks++;
        if (obs_vec() !== 50'h0) begin
            errors++;
            $display("FAIL async_reset: got %h expected %h", obs_vec(), 50'h0);
        end
        q.delete();
        err_exp = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, 32'h0, 1'b0);
        checks++;
        if (obs_vec() !== 50'h0) begin
            errors++;
            $display("FAIL after_reset_release: got %h expected %h", obs_vec(), 50'h0);
        end
    endtask

`ifdef PORT_BUF_ERR_EN
    task automatic test_err_flag();
        do_reset();
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL err_reset: got %b expected 0", err_o);
        end
        step(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        checks++;
        if (err_o !== 1'b1) begin
            errors++;
            $display("FAIL err_underflow_sticky: got %b expected 1", err_o);
        end
        do_reset();
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL err_cleared: got %b expected 0", err_o);
        end
        for (int i = 0; i < DEPTH; i++) step(1'b1, $urandom, 1'b0);
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL err_clean_fill: got %b expected 0", err_o);
        end
        step(1'b1, $urandom, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        checks++;
        if (err_o !== 1'b1) begin
            errors++;
            $display("FAIL err_overflow_sticky: got %b expected 1", err_o);
        end
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 99) < 55), $urandom, 1'($urandom_range(0, 99) < 45));
            checks++;
            if (obs_vec() !== model_vec()) begin
                errors++;
                $display("FAIL random[%0d]: got %h expected %h", i, obs_vec(), model_vec());
            end
`ifdef PORT_BUF_ERR_EN
            checks++;
            if (err_o !== err_exp) begin
                errors++;
                $display("FAIL random_err[%0d]: got %b expected %b", i, err_o, err_exp);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_full_pop();
        test_empty_enq();
        test_mid_reset();
`ifdef PORT_BUF_ERR_EN
        test_err_flag();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
